regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
// Shares the register file's single write port among NUM_REQ writeback sources
// (e.g. ALU, load unit, CSR/mul unit) with round-robin arbitration.
// Registers the winning write into one output stage that drives the regfile
// write port. Provides rs1/rs2 read bypass for the write sitting in that stage,
// which the regfile has not yet committed.
// PARAMETERS
// NUM_REQ  3   number of writeback requesters (2..8)
// DATA_W   32  write data width
// ADDR_W   5   register address width
// PORTS
// i_clk          in   1               clock, all state on rising edge
// i_rst          in   1               reset, asynchronous, active-high
// i_hold         in   1               1 = grant nothing this cycle
// i_req_valid    in   NUM_REQ         per-requester write request
// i_req_addr     in   NUM_REQ*ADDR_W  dest reg, requester k at [k*ADDR_W +: ADDR_W]
// i_req_data     in   NUM_REQ*DATA_W  write data, requester k at [k*DATA_W +: DATA_W]
// o_req_ready    out  NUM_REQ         one-hot grant; accept = valid[k] & ready[k]
// o_rd_wren      out  1               to regfile write enable
// o_rd_addr      out  ADDR_W          to regfile write address
// o_rd_data      out  DATA_W          to regfile write data
// i_rs1_addr     in   ADDR_W          decode-stage read address 1
// i_rs1_rf_data  in   DATA_W          regfile read data 1
// o_rs1_data     out  DATA_W          bypassed read data 1
// i_rs2_addr     in   ADDR_W          decode-stage read address 2
// i_rs2_rf_data  in   DATA_W          regfile read data 2
// o_rs2_data     out  DATA_W          bypassed read data 2
// BEHAVIOUR
// - State: rr_ptr (index of highest-priority requester), output stage
//   {o_rd_wren, o_rd_addr, o_rd_data}.
// - Reset (async, i_rst=1): rr_ptr=0, o_rd_wren=0, o_rd_addr=0, o_rd_data=0.
//   o_req_ready=0 while in reset. A staged write is discarded; un-accepted
//   requesters re-present after reset.
// - Grant (combinational):
//   - Scan k = rr_ptr, rr_ptr+1, ... (mod NUM_REQ); the first k with
//     i_req_valid[k]=1 gets o_req_ready[k]=1.
//   - At most one ready bit is high. A ready bit is never high without its valid.
//   - i_hold=1 forces o_req_ready=0.
// - On accept of requester g: rr_ptr <= (g+1) mod NUM_REQ.
//   With no accept, rr_ptr holds.
// - Fairness: a requester holding valid is accepted within NUM_REQ accepting cycles.
// - Output stage, every cycle:
//   - Accept with addr!=0: o_rd_wren<=1, o_rd_addr<=addr, o_rd_data<=data.
//   - Accept with addr==0: request is consumed and rotates rr_ptr, but o_rd_wren<=0.
//   - No accept: o_rd_wren<=0; o_rd_addr and o_rd_data hold.
// - Latency:
//   - Accept at edge N: o_rd_wren=1 during cycle N..N+1.
//   - Regfile commits at edge N+1. Throughput is 1 write per cycle.
// - Bypass (combinational):
//   - o_rsX_data = o_rd_data when o_rd_wren & (o_rd_addr==i_rsX_addr) & (i_rsX_addr!=0).
//   - Otherwise o_rsX_data = i_rsX_rf_data.
// - Requester contract: once valid rises, addr and data stay stable and valid
//   stays high until accepted. A bench assertion flags violations.
// - Widths: no arithmetic other than rr_ptr increment mod NUM_REQ
//   (explicit wrap, NUM_REQ need not be a power of two).
// TESTING
// 1. Reset: assert i_rst mid-stream with o_rd_wren=1 -> o_rd_wren=0 and rr_ptr=0
//    immediately, before any clock edge.
// 2. All 3 valid for 6 cycles, addrs 1/2/3 -> grants 0,1,2,0,1,2;
//    o_rd_addr 1,2,3,1,2,3 one cycle later.
// 3. Req0 alone, addr=5, data=0xDEADBEEF -> ready0 same cycle; next cycle
//    o_rd_wren=1, o_rd_addr=5, o_rd_data=0xDEADBEEF.
// 4. Req1 addr=0 -> accepted (ready1=1), o_rd_wren stays 0, rr_ptr advances to 2.
// 5. Stage holds x7=0x1234, i_rs1_addr=7, i_rs1_rf_data=0 -> o_rs1_data=0x1234.
//    i_rs2_addr=0 with stage addr 0 -> o_rs2_data=i_rs2_rf_data.
// 6. i_hold=1 for 3 cycles with all valid -> ready=0, o_rd_wren=0, rr_ptr unchanged;
//    release -> grant resumes at the prior rr_ptr.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port among NUM_REQ writeback sources, with rs1/rs2 bypass.
// Latency: a write accepted at edge N drives the write port for one cycle. Backpressure: one-hot ready; i_hold grants nothing.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_hold,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic                      o_rd_wren,
  output logic [ADDR_W-1:0]         o_rd_addr,
  output logic [DATA_W-1:0]         o_rd_data,
  input  logic [ADDR_W-1:0]         i_rs1_addr,
  input  logic [DATA_W-1:0]         i_rs1_rf_data,
  output logic [DATA_W-1:0]         o_rs1_data,
  input  logic [ADDR_W-1:0]         i_rs2_addr,
  input  logic [DATA_W-1:0]         i_rs2_rf_data,
  output logic [DATA_W-1:0]         o_rs2_data
);

  localparam int               PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]   r_rr_ptr;
  logic               r_rd_wren;
  logic [ADDR_W-1:0]  r_rd_addr;
  logic [DATA_W-1:0]  r_rd_data;

  logic [NUM_REQ-1:0] w_grant;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_found;
  logic [PTR_W-1:0]   w_gidx;
  logic [PTR_W-1:0]   w_next_ptr;
  logic               w_accept;
  logic               w_write;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_data;

  // Two ordered passes (k >= ptr, then k < ptr) give the circular scan without modular index math.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_gidx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && i_req_valid[k] && (PTR_W'(k) >= r_rr_ptr)) begin
        w_grant[k] = 1'b1;
        w_found    = 1'b1;
        w_gidx     = PTR_W'(k);
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && i_req_valid[k] && (PTR_W'(k) < r_rr_ptr)) begin
        w_grant[k] = 1'b1;
        w_found    = 1'b1;
        w_gidx     = PTR_W'(k);
      end
    end
  end

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sel_addr = w_sel_addr | ({ADDR_W{w_grant[k]}} & i_req_addr[k*ADDR_W +: ADDR_W]);
      w_sel_data = w_sel_data | ({DATA_W{w_grant[k]}} & i_req_data[k*DATA_W +: DATA_W]);
    end
  end

  assign w_ready    = (i_rst || i_hold) ? '0 : w_grant;
  assign w_accept   = |w_ready;
  assign w_write    = w_accept && (w_sel_addr != '0);
  assign w_next_ptr = (w_gidx == LAST) ? '0 : w_gidx + PTR_W'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rr_ptr  <= '0;
      r_rd_wren <= 1'b0;
      r_rd_addr <= '0;
      r_rd_data <= '0;
    end else begin
      r_rd_wren <= w_write;
      if (w_accept) begin
        r_rr_ptr <= w_next_ptr;
      end
      // x0 writes are consumed but never reach the port, so the stage keeps its last real write.
      if (w_write) begin
        r_rd_addr <= w_sel_addr;
        r_rd_data <= w_sel_data;
      end
    end
  end

  assign o_req_ready = w_ready;
  assign o_rd_wren   = r_rd_wren;
  assign o_rd_addr   = r_rd_addr;
  assign o_rd_data   = r_rd_data;

  assign o_rs1_data = (r_rd_wren && (r_rd_addr == i_rs1_addr) && (i_rs1_addr != '0)) ? r_rd_data : i_rs1_rf_data;
  assign o_rs2_data = (r_rd_wren && (r_rd_addr == i_rs2_addr) && (i_rs2_addr != '0)) ? r_rd_data : i_rs2_rf_data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: grant order, staging, x0 handling, bypass, hold and async reset.
module tb_regfile_wb_arbiter;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            hold;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            rd_wren;
  logic [AW-1:0]   rd_addr;
  logic [DW-1:0]   rd_data;
  logic [AW-1:0]   rs1_addr, rs2_addr;
  logic [DW-1:0]   rs1_rf_data, rs2_rf_data, rs1_data, rs2_data;

  int n_pass = 0;
  int n_total = 0;
  int n_contract_fail = 0;

  regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_hold(hold),
    .i_req_valid(req_valid), .i_req_addr(req_addr), .i_req_data(req_data),
    .o_req_ready(req_ready),
    .o_rd_wren(rd_wren), .o_rd_addr(rd_addr), .o_rd_data(rd_data),
    .i_rs1_addr(rs1_addr), .i_rs1_rf_data(rs1_rf_data), .o_rs1_data(rs1_data),
    .i_rs2_addr(rs2_addr), .i_rs2_rf_data(rs2_rf_data), .o_rs2_data(rs2_data)
  );

  always #5 clk = ~clk;

  // Requester contract: a pending (valid, not accepted) request must stay valid and stable.
  logic [N-1:0]    pend;
  logic [N*AW-1:0] pend_addr;
  logic [N*DW-1:0] pend_data;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (pend[k] && (!req_valid[k] || req_addr[k*AW +: AW] != pend_addr[k*AW +: AW] ||
                        req_data[k*DW +: DW] != pend_data[k*DW +: DW])) begin
          $display("FAIL contract_req%0d: pending request dropped or changed", k);
          n_contract_fail++;
        end
      end
      pend      <= req_valid & ~req_ready;
      pend_addr <= req_addr;
      pend_data <= req_data;
    end
  end

  task automatic set_req(input int k, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[k]         = v;
    req_addr[k*AW +: AW] = a;
    req_data[k*DW +: DW] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; hold = 1'b0;
    req_valid = '0; req_addr = '0; req_data = '0;
    rs1_addr = '0; rs2_addr = '0; rs1_rf_data = '0; rs2_rf_data = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    set_req(0, 1'b1, 5'd4, 32'h44);
    set_req(1, 1'b1, 5'd5, 32'h55);
    set_req(2, 1'b1, 5'd6, 32'h66);
    #1;
    n_total++; if (req_ready !== 3'b000) $display("FAIL reset_ready: got %b want 000", req_ready); else n_pass++;
    n_total++; if (rd_wren !== 1'b0) $display("FAIL reset_wren: got %b want 0", rd_wren); else n_pass++;
    step();
    rst = 1'b0;
    @(negedge clk);
    n_total++; if (req_ready !== 3'b001) $display("FAIL reset_first_grant: got %b want 001", req_ready); else n_pass++;
    step();
    @(negedge clk);
    n_total++; if (rd_wren !== 1'b1 || rd_addr !== 5'd4) $display("FAIL pre_reset_stage: got wren=%b addr=%0d want 1/4", rd_wren, rd_addr); else n_pass++;
    n_total++; if (req_ready !== 3'b010) $display("FAIL pre_reset_ptr: got %b want 010", req_ready); else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_total++; if (rd_wren !== 1'b0 || rd_addr !== 5'd0 || rd_data !== 32'h0)
      $display("FAIL async_reset_stage: got wren=%b addr=%0d data=%h want 0/0/0", rd_wren, rd_addr, rd_data); else n_pass++;
    n_total++; if (req_ready !== 3'b000) $display("FAIL async_reset_ready: got %b want 000", req_ready); else n_pass++;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_total++; if (req_ready !== 3'b001) $display("FAIL async_reset_ptr: got %b want 001", req_ready); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_ready;
    logic [AW-1:0] exp_addr;
    do_reset();
    for (int k = 0; k < N; k++) set_req(k, 1'b1, AW'(k + 1), 32'hA000 + DW'(k));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_ready = 3'b001 << (i % 3);
      n_total++; if (req_ready !== exp_ready) $display("FAIL rr_grant_%0d: got %b want %b", i, req_ready, exp_ready); else n_pass++;
      if (i > 0) begin
        exp_addr = AW'(((i - 1) % 3) + 1);
        n_total++; if (rd_wren !== 1'b1 || rd_addr !== exp_addr)
          $display("FAIL rr_stage_%0d: got wren=%b addr=%0d want 1/%0d", i, rd_wren, rd_addr, exp_addr); else n_pass++;
      end
      step();
    end
    @(negedge clk);
    n_total++; if (rd_wren !== 1'b1 || rd_addr !== 5'd3 || rd_data !== 32'hA002)
      $display("FAIL rr_stage_last: got wren=%b addr=%0d data=%h want 1/3/0000a002", rd_wren, rd_addr, rd_data); else n_pass++;
  endtask

  task automatic test_single_write();
    do_reset();
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    n_total++; if (req_ready !== 3'b001) $display("FAIL single_ready: got %b want 001", req_ready); else n_pass++;
    step();
    set_req(0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    n_total++; if (rd_wren !== 1'b1 || rd_addr !== 5'd5 || rd_data !== 32'hDEADBEEF)
      $display("FAIL single_stage: got wren=%b addr=%0d data=%h want 1/5/deadbeef", rd_wren, rd_addr, rd_data); else n_pass++;
    step();
    @(negedge clk);
    n_total++; if (rd_wren !== 1'b0 || rd_addr !== 5'd5 || rd_data !== 32'hDEADBEEF)
      $display("FAIL single_idle_hold: got wren=%b addr=%0d data=%h want 0/5/deadbeef", rd_wren, rd_addr, rd_data); else n_pass++;
  endtask

  task automatic test_x0_write();
    do_reset();
    set_req(0, 1'b1, 5'd9, 32'h99);
    step();
    set_req(0, 1'b0, 5'd0, 32'h0);
    set_req(1, 1'b1, 5'd0, 32'h1111);
    @(negedge clk);
    n_total++; if (req_ready !== 3'b010) $display("FAIL x0_ready: got %b want 010", req_ready); else n_pass++;
    step();
    set_req(1, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    n_total++; if (rd_wren !== 1'b0 || rd_addr !== 5'd9)
      $display("FAIL x0_stage: got wren=%b addr=%0d want 0/9", rd_wren, rd_addr); else n_pass++;
    for (int k = 0; k < N; k++) set_req(k, 1'b1, AW'(k + 1), 32'h0);
    #1;
    n_total++; if (req_ready !== 3'b100) $display("FAIL x0_ptr_advance: got %b want 100", req_ready); else n_pass++;
  endtask

  task automatic test_bypass();
    do_reset();
    set_req(0, 1'b1, 5'd7, 32'h1234);
    rs2_addr = 5'd0; rs2_rf_data = 32'hAAAA;
    #1;
    n_total++; if (rs2_data !== 32'hAAAA) $display("FAIL bypass_x0_stage0: got %h want 0000aaaa", rs2_data); else n_pass++;
    step();
    set_req(0, 1'b0, 5'd0, 32'h0);
    rs1_addr = 5'd7; rs1_rf_data = 32'h0;
    @(negedge clk);
    n_total++; if (rs1_data !== 32'h1234) $display("FAIL bypass_hit: got %h want 00001234", rs1_data); else n_pass++;
    n_total++; if (rs2_data !== 32'hAAAA) $display("FAIL bypass_rs2_x0: got %h want 0000aaaa", rs2_data); else n_pass++;
    rs2_addr = 5'd8; rs2_rf_data = 32'h5555;
    #1;
    n_total++; if (rs2_data !== 32'h5555) $display("FAIL bypass_miss: got %h want 00005555", rs2_data); else n_pass++;
    step();
    rs1_rf_data = 32'h7777;
    @(negedge clk);
    n_total++; if (rs1_data !== 32'h7777) $display("FAIL bypass_stale: got %h want 00007777", rs1_data); else n_pass++;
  endtask

  task automatic test_hold();
    do_reset();
    for (int k = 0; k < N; k++) set_req(k, 1'b1, AW'(k + 1), 32'hB000 + DW'(k));
    step();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++; if (req_ready !== 3'b000) $display("FAIL hold_ready_%0d: got %b want 000", i, req_ready); else n_pass++;
      if (i > 0) begin
        n_total++; if (rd_wren !== 1'b0) $display("FAIL hold_wren_%0d: got %b want 0", i, rd_wren); else n_pass++;
      end
      step();
    end
    hold = 1'b0;
    #1;
    n_total++; if (req_ready !== 3'b010) $display("FAIL hold_resume: got %b want 010", req_ready); else n_pass++;
    step();
    @(negedge clk);
    n_total++; if (rd_wren !== 1'b1 || rd_addr !== 5'd2 || rd_data !== 32'hB001)
      $display("FAIL hold_resume_stage: got wren=%b addr=%0d data=%h want 1/2/0000b001", rd_wren, rd_addr, rd_data); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_write();
    test_x0_write();
    test_bypass();
    test_hold();
    do_reset();
    n_total = n_total + n_contract_fail;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
